// File: rtl/prog_prescaler.sv
// Programmable multi-channel clock prescaler.
// Each channel divides clk by its own runtime-writable divisor D, producing a
// registered one-cycle tick every D cycles and a 50%-duty clock of period 2*D.
// A divisor of 0 parks the channel with both outputs low. sync realigns every
// channel to count 0 with clk_out low, so channels with equal divisors run in
// lockstep afterwards.
module prog_prescaler #(
  parameter int N       = 4,
  parameter int CH      = 3,
  parameter int DIV_RST = 8,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [N-1:0]   wr_div,
  output logic [CH-1:0]  clk_out,
  output logic [CH-1:0]  tick
);

  localparam logic [N-1:0] DIV_RST_V = N'(DIV_RST);
  localparam logic [N-1:0] ONE       = N'(1);

  logic [N-1:0]  div_q [CH];
  logic [N-1:0]  div_d [CH];
  logic [N-1:0]  cnt_q [CH];
  logic [N-1:0]  cnt_d [CH];
  logic [CH-1:0] clk_out_q, clk_out_d;
  logic [CH-1:0] tick_q, tick_d;
  logic [CH-1:0] wr_hit;

  // Decode the write address; indices at or above CH never match any channel.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == CHW'(i));
    end
  end

  // Per-channel next state: clear (sync/write) beats disable beats counting.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      div_d[i]     = div_q[i];
      cnt_d[i]     = cnt_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = 1'b0;
      if (sync || wr_hit[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        if (wr_hit[i]) begin
          div_d[i] = wr_div;
        end
      end else if (div_q[i] == '0) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (en) begin
        if (cnt_q[i] == div_q[i] - ONE) begin
          cnt_d[i]     = '0;
          tick_d[i]    = 1'b1;
          clk_out_d[i] = ~clk_out_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  // State registers; reset reloads the default divisor and clears everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        div_q[i] <= DIV_RST_V;
        cnt_q[i] <= '0;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule
